// File: rtl/i2c_cmd_pkg.sv
// Shared definitions for the I2C handler command arbiter: command/status bit
// positions and the sequencing state encoding.
package i2c_cmd_pkg;

    localparam int CMD_ADDR_LSB = 0;
    localparam int CMD_DATA_LSB = 16;
    localparam int CMD_WR       = 28;
    localparam int CMD_RUN      = 29;
    localparam int CMD_FRZ      = 30;
    localparam int CMD_RST      = 31;

    localparam int ST_RUN_STAT  = 29;
    localparam int ST_ERR       = 28;
    localparam int ST_DOUT_LSB  = 16;

    localparam int TMR_W        = 24;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_SETTLE     = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_RESPOND    = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic NREQ-way round-robin arbiter: one-hot grant searched from the pointer,
// pointer moves to (winner + 1) mod NREQ only when i_upd_en is asserted.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_upd_en,
    output logic [NREQ-1:0] o_grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_next_ptr;
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_grot;
    logic            w_found;

    // Rotate so the pointer position becomes bit 0, pick the lowest set bit,
    // then rotate the grant back.
    always_comb begin
        w_rot   = NREQ'(({i_req, i_req}) >> r_ptr);
        w_grot  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_rot[i] && !w_found) begin
                w_grot[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
        o_grant = NREQ'(({w_grot, w_grot} << r_ptr) >> NREQ);
    end

    always_comb begin
        w_next_ptr = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (o_grant[i]) begin
                w_next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_upd_en) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares the I2C handler command/status port between NREQ requesters, one
// command in flight, waiting out run commands before returning status.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | offer req_ready to the round-robin winner, accept command
// S_ISSUE      | single-cycle csrStrobe with the command on GPIO_OUT
// S_SETTLE     | wait SETTLE_CYCLES for handler register + table latency
// S_WAIT_START | run command: wait for run_stat to rise (START_TIMEOUT)
// S_WAIT_DONE  | run command: wait for run_stat to fall (DONE_TIMEOUT)
// S_RESPOND    | one-cycle rsp_valid to the issuing requester
module i2c_cmd_arbiter
    import i2c_cmd_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int START_TIMEOUT = 64,
    parameter int DONE_TIMEOUT  = 1 << 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [32*NREQ-1:0]  req_cmd,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [31:0]         rsp_status,
    output logic                rsp_timeout,
    output logic                csrStrobe,
    output logic [31:0]         GPIO_OUT,
    input  logic [31:0]         status,
    output logic                busy
);

    localparam logic [TMR_W-1:0] SETTLE_TC = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] START_TC  = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] DONE_TC   = TMR_W'(DONE_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [NREQ-1:0]    r_req_ready;
    logic [NREQ-1:0]    r_gnt;
    logic [31:0]        r_cmd;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_timeout;
    logic [31:0]        r_rsp_status;

    logic [NREQ-1:0]    w_arb_req;
    logic [NREQ-1:0]    w_grant;
    logic               w_accept;
    logic               w_set_to;
    logic [31:0]        w_sel_cmd;

    assign w_accept = (r_state == S_IDLE) && (|(r_req_ready & req_valid));

    // While an offer is outstanding the arbiter only sees the offered requester,
    // so its grant equals the accepted one when the pointer is updated.
    assign w_arb_req = (|r_req_ready) ? (r_req_ready & req_valid) : req_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_arb_req),
        .i_upd_en (w_accept),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_sel_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_req_ready[i]) begin
                w_sel_cmd = w_sel_cmd | req_cmd[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_set_to = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_next = S_SETTLE;
            end
            S_SETTLE: begin
                // Engine reset overrides run: the engine will not start.
                if (r_tmr >= SETTLE_TC) begin
                    w_next = (r_cmd[CMD_RUN] && !r_cmd[CMD_RST]) ? S_WAIT_START : S_RESPOND;
                end
            end
            S_WAIT_START: begin
                if (status[ST_RUN_STAT]) begin
                    w_next = S_WAIT_DONE;
                end else if (r_tmr >= START_TC) begin
                    w_next   = S_RESPOND;
                    w_set_to = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!status[ST_RUN_STAT]) begin
                    w_next = S_RESPOND;
                end else if (r_tmr >= DONE_TC) begin
                    w_next   = S_RESPOND;
                    w_set_to = 1'b1;
                end
            end
            S_RESPOND: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready  <= '0;
            r_gnt        <= '0;
            r_cmd        <= '0;
            r_tmr        <= '0;
            r_timeout    <= 1'b0;
            r_rsp_status <= '0;
        end else begin
            r_req_ready <= (r_state == S_IDLE && r_req_ready == '0) ? w_grant : '0;
            if (w_accept) begin
                r_cmd     <= w_sel_cmd;
                r_gnt     <= r_req_ready;
                r_timeout <= 1'b0;
            end
            if (w_set_to) begin
                r_timeout <= 1'b1;
            end
            if (w_next == S_RESPOND && r_state != S_RESPOND) begin
                r_rsp_status <= status;
            end
            if (w_next != r_state) begin
                r_tmr <= '0;
            end else if (r_tmr != '1) begin
                r_tmr <= r_tmr + 1'b1;
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = (r_state == S_RESPOND) ? r_gnt : '0;
    assign rsp_status  = r_rsp_status;
    assign rsp_timeout = (r_state == S_RESPOND) && r_timeout;
    assign csrStrobe   = (r_state == S_ISSUE);
    assign GPIO_OUT    = r_cmd;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with hand-computed latencies, grants
// and response values.
module tb_i2c_cmd_arbiter;

    localparam int NREQ = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_cmd;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_status;
    logic               rsp_timeout;
    logic               csrStrobe;
    logic [31:0]        GPIO_OUT;
    logic [31:0]        status;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    i2c_cmd_arbiter u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_status  (rsp_status),
        .rsp_timeout (rsp_timeout),
        .csrStrobe   (csrStrobe),
        .GPIO_OUT    (GPIO_OUT),
        .status      (status),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command from a single requester; returns in the strobe cycle.
    task automatic issue(input int idx, input logic [31:0] cmd, input string tag);
        int n;
        n = 0;
        req_cmd[32*idx +: 32] = cmd;
        req_valid[idx] = 1'b1;
        while (req_ready[idx] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_grant"}, 32'(req_ready), 32'(1 << idx));
        tick();
        req_valid[idx] = 1'b0;
        chk({tag, "_strobe"}, 32'(csrStrobe), 32'd1);
        chk({tag, "_gpio"}, GPIO_OUT, cmd);
    endtask

    task automatic wait_rsp(input int max, output int cyc, output int strobes);
        cyc     = 0;
        strobes = 0;
        while (rsp_valid == '0 && cyc < max) begin
            tick();
            cyc++;
            if (csrStrobe) strobes++;
        end
    endtask

    initial begin
        int cyc;
        int st;
        int bad;
        int n;
        int exp_idx;

        rst_n     = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        status    = '0;
        repeat (3) tick();
        chk("rst_ctl", {27'd0, busy, csrStrobe, rsp_timeout, 2'b00} | 32'(req_ready) | 32'(rsp_valid), 32'd0);
        chk("rst_gpio", GPIO_OUT, 32'd0);
        chk("rst_status", rsp_status, 32'd0);
        rst_n = 1'b1;
        tick();

        // single read from requester 0: response 4 cycles after the strobe
        status = 32'h00A5_0000;
        issue(0, 32'h0000_0012, "rd0");
        wait_rsp(20, cyc, st);
        chk("rd0_lat", cyc, 32'd4);
        chk("rd0_rsp", 32'(rsp_valid), 32'd1);
        chk("rd0_dout", 32'(rsp_status[23:16]), 32'h0000_00A5);
        chk("rd0_to", 32'(rsp_timeout), 32'd0);
        chk("rd0_strobes", st, 32'd0);
        tick();
        chk("rd0_pulse", 32'(rsp_valid), 32'd0);
        chk("rd0_idle", 32'(busy), 32'd0);

        // requester 1 offered but withdraws before acceptance
        req_cmd[63:32] = 32'h0000_0055;
        req_valid[1] = 1'b1;
        tick();
        chk("drop_offer", 32'(req_ready), 32'd2);
        req_valid[1] = 1'b0;
        tick();
        chk("drop_ready", 32'(req_ready), 32'd0);
        repeat (3) tick();
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_gpio", GPIO_OUT, 32'h0000_0012);

        // both valid continuously: pointer sits at 1 after the read from 0
        req_cmd   = {32'h0000_0202, 32'h0000_0101};
        req_valid = 2'b11;
        exp_idx   = 1;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (req_ready == '0 && n < 20) begin
                tick();
                n++;
            end
            chk("alt_grant", 32'(req_ready), 32'(1 << exp_idx));
            wait_rsp(20, cyc, st);
            chk("alt_strobes", st, 32'd1);
            chk("alt_rsp", 32'(rsp_valid), 32'(1 << exp_idx));
            chk("alt_gpio", GPIO_OUT, (exp_idx == 1) ? 32'h0000_0202 : 32'h0000_0101);
            exp_idx = 1 - exp_idx;
        end
        req_valid = '0;
        tick();

        // run command: run_stat rises 10 cycles after strobe, falls 500 later
        status = 32'h0000_0000;
        issue(0, 32'h2000_0000, "run");
        bad = 0;
        repeat (10) begin
            tick();
            if (rsp_valid != '0) bad++;
        end
        status[29] = 1'b1;
        repeat (500) begin
            tick();
            if (rsp_valid != '0) bad++;
        end
        status[29] = 1'b0;
        chk("run_early", bad, 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        tick();
        chk("run_rsp", 32'(rsp_valid), 32'd1);
        chk("run_to", 32'(rsp_timeout), 32'd0);
        tick();

        // run_stat never rises: strobe + 4 settle/entry + 64 timeout cycles
        issue(1, 32'h2000_0034, "tmo");
        wait_rsp(200, cyc, st);
        chk("tmo_lat", cyc, 32'd68);
        chk("tmo_rsp", 32'(rsp_valid), 32'd2);
        chk("tmo_to", 32'(rsp_timeout), 32'd1);
        tick();
        issue(0, 32'h0001_0007, "after");
        wait_rsp(20, cyc, st);
        chk("after_lat", cyc, 32'd4);
        chk("after_rsp", 32'(rsp_valid), 32'd1);
        chk("after_to", 32'(rsp_timeout), 32'd0);
        tick();

        // engine reset skips run waiting even with the run bit set
        issue(1, 32'hE000_0000, "ersr");
        wait_rsp(200, cyc, st);
        chk("ersr_lat", cyc, 32'd4);
        chk("ersr_rsp", 32'(rsp_valid), 32'd2);
        tick();
        issue(0, 32'hC000_0000, "erst");
        wait_rsp(200, cyc, st);
        chk("erst_lat", cyc, 32'd4);
        chk("erst_to", 32'(rsp_timeout), 32'd0);
        repeat (5) tick();
        chk("erst_hold", GPIO_OUT, 32'hC000_0000);

        // reset during WAIT_DONE (pointer is 1 after the grant to 0)
        issue(0, 32'h2000_0001, "rstmid");
        repeat (4) tick();
        status[29] = 1'b1;
        repeat (3) tick();
        chk("rstmid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ctl", {28'd0, busy, csrStrobe, rsp_timeout, 1'b0} | 32'(req_ready) | 32'(rsp_valid), 32'd0);
        chk("rstmid_gpio", GPIO_OUT, 32'd0);
        chk("rstmid_status", rsp_status, 32'd0);
        tick();
        rst_n = 1'b1;
        status[29] = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (rsp_valid != '0) bad++;
        end
        chk("rstmid_norsp", bad, 32'd0);
        req_valid = 2'b11;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("rstmid_grant", 32'(req_ready), 32'd1);
        req_valid = '0;
        wait_rsp(20, cyc, st);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
